// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file.
package regfile_pkg;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  // Widest data path the init-value helper can produce; callers size-cast down.
  localparam int INIT_W = 64;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic logic [INIT_W-1:0] init_value(input logic [INIT_W-1:0] idx,
                                                   input logic mode);
    return mode ? idx : '0;
  endfunction

endpackage

// File: rtl/regfile_read_lane.sv
// One read port: zero-register / write-through bypass / memory select.
// Latency: combinational. Backpressure: none; lane reads 0 until the file is ready.
module regfile_read_lane
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              i_ready,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_dat,
  input  logic [DATA_W-1:0] i_mem_dat,
  output logic [DATA_W-1:0] o_rd_dat
);

  logic w_zero_hit;
  logic w_byp_hit;

  assign w_zero_hit = (ZERO_REG != 0) && (i_rd_addr == '0);
  assign w_byp_hit  = i_wr_en && (i_wr_addr == i_rd_addr);

  // Zero register outranks the bypass so a write to entry 0 never leaks through.
  always_comb begin
    o_rd_dat = i_mem_dat;
    if (!i_ready || w_zero_hit) begin
      o_rd_dat = '0;
    end else if (w_byp_hit) begin
      o_rd_dat = i_wr_dat;
    end
  end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file with N_RD combinational read ports, one write port and a
// reset-driven init sequencer. Latency: reads combinational, writes visible next cycle.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int N_RD      = 2,
  parameter int ZERO_REG  = 1,
  parameter int INIT_MODE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     RegWrt,
  input  logic [ADDR_W-1:0]        WrtReg,
  input  logic [DATA_W-1:0]        WrtData,
  input  logic [N_RD*ADDR_W-1:0]   RdReg,
  output logic [N_RD*DATA_W-1:0]   RdData,
  output logic                     ready,
  output logic                     init_busy
);

  localparam int                DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_init_cnt;
  logic [ADDR_W-1:0] w_init_cnt_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_we;
  logic [ADDR_W-1:0] w_wa;
  logic [DATA_W-1:0] w_wd;
  logic [DATA_W-1:0] w_init_dat;
  logic              w_run_wr;
  logic              w_byp_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    if (r_state == INIT) begin
      w_init_cnt_nxt = r_init_cnt + 1'b1;
      if (r_init_cnt == LAST) begin
        w_state_nxt = RUN;
      end
    end
  end

  assign ready     = (r_state == RUN);
  assign init_busy = ~ready;

  assign w_init_dat = DATA_W'(init_value(INIT_W'(r_init_cnt), INIT_MODE != 0));
  assign w_run_wr   = ready && RegWrt && !((ZERO_REG != 0) && (WrtReg == '0));
  assign w_byp_en   = ready && RegWrt;

  // Sequencer and writeback share the single write port; reset cycles write nothing.
  always_comb begin
    w_we = 1'b0;
    w_wa = WrtReg;
    w_wd = WrtData;
    if (!rst) begin
      if (r_state == INIT) begin
        w_we = 1'b1;
        w_wa = r_init_cnt;
        w_wd = w_init_dat;
      end else if (w_run_wr) begin
        w_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_wa] <= w_wd;
    end
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    regfile_read_lane #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_lane (
      .i_ready   (ready),
      .i_rd_addr (RdReg[k*ADDR_W +: ADDR_W]),
      .i_wr_en   (w_byp_en),
      .i_wr_addr (WrtReg),
      .i_wr_dat  (WrtData),
      .i_mem_dat (r_mem[RdReg[k*ADDR_W +: ADDR_W]]),
      .o_rd_dat  (RdData[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench: three regfile_param configurations against an array-based model.
module tb_regfile_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // A (defaults) and B (ZERO_REG=0) share one stimulus set.
  logic        rst, we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [9:0]  rr;
  logic [63:0] rd_a, rd_b;
  logic        rdy_a, busy_a, rdy_b, busy_b;

  logic        rst_c, we_c;
  logic [2:0]  wa_c;
  logic [7:0]  wd_c;
  logic [8:0]  rr_c;
  logic [23:0] rd_c;
  logic        rdy_c, busy_c;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] m_a [32];
  logic [31:0] m_b [32];
  logic [7:0]  m_c [8];
  bit run_ab = 0, run_c = 0;
  int left_ab = 0, left_c = 0;

  regfile_param u_a (
    .clk(clk), .rst(rst), .RegWrt(we), .WrtReg(wa), .WrtData(wd), .RdReg(rr),
    .RdData(rd_a), .ready(rdy_a), .init_busy(busy_a)
  );

  regfile_param #(.ZERO_REG(0)) u_b (
    .clk(clk), .rst(rst), .RegWrt(we), .WrtReg(wa), .WrtData(wd), .RdReg(rr),
    .RdData(rd_b), .ready(rdy_b), .init_busy(busy_b)
  );

  regfile_param #(.DATA_W(8), .ADDR_W(3), .N_RD(3), .INIT_MODE(0)) u_c (
    .clk(clk), .rst(rst_c), .RegWrt(we_c), .WrtReg(wa_c), .WrtData(wd_c), .RdReg(rr_c),
    .RdData(rd_c), .ready(rdy_c), .init_busy(busy_c)
  );

  // Reference: after reset, DEPTH non-reset edges fill the file, then writes apply.
  function automatic logic [31:0] ref_ab(input bit zr, input logic [4:0] ra);
    if (!run_ab) return 32'd0;
    if (zr && ra == 5'd0) return 32'd0;
    if (we && wa == ra) return wd;
    return zr ? m_a[ra] : m_b[ra];
  endfunction

  function automatic logic [7:0] ref_c(input logic [2:0] ra);
    if (!run_c) return 8'd0;
    if (ra == 3'd0) return 8'd0;
    if (we_c && wa_c == ra) return wd_c;
    return m_c[ra];
  endfunction

  task automatic step_ab();
    if (rst) begin
      run_ab  = 0;
      left_ab = 32;
    end else if (!run_ab) begin
      left_ab--;
      if (left_ab == 0) begin
        run_ab = 1;
        for (int i = 0; i < 32; i++) begin
          m_a[i] = 32'(i);
          m_b[i] = 32'(i);
        end
      end
    end else if (we) begin
      if (wa != 5'd0) m_a[wa] = wd;
      m_b[wa] = wd;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step_c();
    if (rst_c) begin
      run_c  = 0;
      left_c = 8;
    end else if (!run_c) begin
      left_c--;
      if (left_c == 0) begin
        run_c = 1;
        for (int i = 0; i < 8; i++) m_c[i] = 8'd0;
      end
    end else if (we_c && wa_c != 3'd0) begin
      m_c[wa_c] = wd_c;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int cnt;
    rst = 1; we = 0; wa = 0; wd = 0; rr = 0;
    step_ab();
    step_ab();
    n_chk++;
    if (rdy_a !== 1'b0 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b init_busy=%b, want 0/1", rdy_a, busy_a);
    end
    rst = 0;
    cnt = 0;
    while (rdy_a !== 1'b1 && cnt < 40) begin
      rr = 10'($urandom);
      #1;
      n_chk++;
      if (rd_a !== 64'd0 || busy_a !== 1'b1) begin
        n_fail++;
        $display("FAIL init_read cyc %0d: rd=%h busy=%b, want 0/1", cnt, rd_a, busy_a);
      end
      step_ab();
      cnt++;
    end
    n_chk++;
    if (cnt != 32 || rdy_b !== 1'b1 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL init_len: %0d cycles rdy_b=%b busy=%b, want 32/1/0", cnt, rdy_b, busy_a);
    end
    rr = {5'd31, 5'd7};
    #1;
    n_chk++;
    if (rd_a !== {32'd31, 32'd7} || rd_b !== {32'd31, 32'd7}) begin
      n_fail++;
      $display("FAIL init_vals_a: a=%h b=%h, want %h", rd_a, rd_b, {32'd31, 32'd7});
    end
    rr = {5'd7, 5'd31};
    #1;
    n_chk++;
    if (rd_a !== {32'd7, 32'd31}) begin
      n_fail++;
      $display("FAIL init_vals_b: got %h, want %h", rd_a, {32'd7, 32'd31});
    end
  endtask

  task automatic test_write();
    we = 1; wa = 5'd5; wd = 32'hDEADBEEF; rr = {5'd6, 5'd6};
    step_ab();
    we = 0; rr = {5'd5, 5'd5};
    #1;
    n_chk++;
    if (rd_a !== {2{32'hDEADBEEF}} || rd_b !== {2{32'hDEADBEEF}}) begin
      n_fail++;
      $display("FAIL write_rb: a=%h b=%h, want %h", rd_a, rd_b, {2{32'hDEADBEEF}});
    end
    rr = {5'd6, 5'd5};
    #1;
    n_chk++;
    if (rd_a !== {32'd6, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL write_neighbour: got %h, want %h", rd_a, {32'd6, 32'hDEADBEEF});
    end
  endtask

  task automatic test_bypass();
    we = 1; wa = 5'd9; wd = 32'h12345678; rr = {5'd10, 5'd9};
    #1;
    n_chk++;
    if (rd_a !== {32'd10, 32'h12345678}) begin
      n_fail++;
      $display("FAIL bypass: got %h, want %h", rd_a, {32'd10, 32'h12345678});
    end
    step_ab();
    we = 0; rr = {5'd9, 5'd9};
    #1;
    n_chk++;
    if (rd_a !== {2{32'h12345678}}) begin
      n_fail++;
      $display("FAIL bypass_commit: got %h, want %h", rd_a, {2{32'h12345678}});
    end
  endtask

  task automatic test_zero();
    we = 1; wa = 5'd0; wd = 32'hFFFFFFFF; rr = {5'd2, 5'd1};
    step_ab();
    we = 0; rr = {5'd0, 5'd0};
    #1;
    n_chk++;
    if (rd_a !== 64'd0) begin
      n_fail++;
      $display("FAIL zero_reg: got %h, want 0", rd_a);
    end
    n_chk++;
    if (rd_b !== {2{32'hFFFFFFFF}}) begin
      n_fail++;
      $display("FAIL zero_off: got %h, want %h", rd_b, {2{32'hFFFFFFFF}});
    end
    we = 1; wa = 5'd0; wd = 32'h13579BDF;
    #1;
    n_chk++;
    if (rd_a !== 64'd0 || rd_b !== {2{32'h13579BDF}}) begin
      n_fail++;
      $display("FAIL zero_bypass: a=%h b=%h, want 0 / %h", rd_a, rd_b, {2{32'h13579BDF}});
    end
    step_ab();
    we = 0;
  endtask

  task automatic test_reset_mid();
    int cnt;
    rst = 1;
    step_ab();
    rst = 0;
    for (int i = 0; i < 10; i++) step_ab();
    rst = 1;
    step_ab();
    rst = 0;
    we = 1; wa = 5'd4; wd = 32'h55;
    cnt = 0;
    while (rdy_a !== 1'b1 && cnt < 40) begin
      step_ab();
      cnt++;
    end
    we = 0;
    n_chk++;
    if (cnt != 32) begin
      n_fail++;
      $display("FAIL reinit_len: %0d cycles, want 32", cnt);
    end
    rr = {5'd3, 5'd4};
    #1;
    n_chk++;
    if (rd_a !== {32'd3, 32'd4}) begin
      n_fail++;
      $display("FAIL init_drop_wr: got %h, want %h", rd_a, {32'd3, 32'd4});
    end
    we = 1; wa = 5'd3; wd = 32'hAA;
    step_ab();
    we = 0;
    #1;
    n_chk++;
    if (rd_a[63:32] !== 32'hAA) begin
      n_fail++;
      $display("FAIL run_wr_r3: got %h, want aa", rd_a[63:32]);
    end
    rst = 1;
    step_ab();
    rst = 0;
    n_chk++;
    if (rdy_a !== 1'b0 || busy_a !== 1'b1 || rd_a !== 64'd0) begin
      n_fail++;
      $display("FAIL run_rst: ready=%b busy=%b rd=%h, want 0/1/0", rdy_a, busy_a, rd_a);
    end
    cnt = 0;
    while (rdy_a !== 1'b1 && cnt < 40) begin
      step_ab();
      cnt++;
    end
    #1;
    n_chk++;
    if (cnt != 32 || rd_a[63:32] !== 32'd3) begin
      n_fail++;
      $display("FAIL rerun_r3: %0d cycles r3=%h, want 32 / 3", cnt, rd_a[63:32]);
    end
  endtask

  task automatic test_random_ab();
    logic [31:0] exp;
    for (int it = 0; it < 300; it++) begin
      we = 1'($urandom);
      wa = 5'($urandom);
      wd = $urandom;
      for (int k = 0; k < 2; k++)
        rr[k*5 +: 5] = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      #1;
      for (int k = 0; k < 2; k++) begin
        exp = ref_ab(1'b1, rr[k*5 +: 5]);
        n_chk++;
        if (rd_a[k*32 +: 32] !== exp) begin
          n_fail++;
          $display("FAIL rand_a it%0d lane%0d: got %h, want %h", it, k, rd_a[k*32 +: 32], exp);
        end
        exp = ref_ab(1'b0, rr[k*5 +: 5]);
        n_chk++;
        if (rd_b[k*32 +: 32] !== exp) begin
          n_fail++;
          $display("FAIL rand_b it%0d lane%0d: got %h, want %h", it, k, rd_b[k*32 +: 32], exp);
        end
      end
      step_ab();
    end
    we = 0;
  endtask

  task automatic test_sweep_c();
    int cnt;
    logic [7:0] exp;
    rst_c = 1;
    step_c();
    rst_c = 0;
    cnt = 0;
    while (rdy_c !== 1'b1 && cnt < 20) begin
      n_chk++;
      if (rd_c !== 24'd0 || busy_c !== 1'b1) begin
        n_fail++;
        $display("FAIL c_init_read: rd=%h busy=%b, want 0/1", rd_c, busy_c);
      end
      step_c();
      cnt++;
    end
    n_chk++;
    if (cnt != 8) begin
      n_fail++;
      $display("FAIL c_init_len: %0d cycles, want 8", cnt);
    end
    for (int i = 0; i < 8; i++) begin
      rr_c = {3'(i), 3'(i), 3'(i)};
      #1;
      n_chk++;
      if (rd_c !== 24'd0) begin
        n_fail++;
        $display("FAIL c_init_zero r%0d: got %h, want 0", i, rd_c);
      end
    end
    we_c = 1; wa_c = 3'd1; wd_c = 8'h11; rr_c = 9'd0;
    step_c();
    wa_c = 3'd2; wd_c = 8'h22;
    step_c();
    wa_c = 3'd7; wd_c = 8'h77;
    step_c();
    we_c = 0; rr_c = {3'd7, 3'd2, 3'd1};
    #1;
    n_chk++;
    if (rd_c !== {8'h77, 8'h22, 8'h11}) begin
      n_fail++;
      $display("FAIL c_three_ports: got %h, want %h", rd_c, {8'h77, 8'h22, 8'h11});
    end
    for (int it = 0; it < 150; it++) begin
      we_c = 1'($urandom);
      wa_c = 3'($urandom);
      wd_c = 8'($urandom);
      rr_c = 9'($urandom);
      #1;
      for (int k = 0; k < 3; k++) begin
        exp = ref_c(rr_c[k*3 +: 3]);
        n_chk++;
        if (rd_c[k*8 +: 8] !== exp) begin
          n_fail++;
          $display("FAIL rand_c it%0d lane%0d: got %h, want %h", it, k, rd_c[k*8 +: 8], exp);
        end
      end
      step_c();
    end
    we_c = 0;
  endtask

  initial begin
    rst_c = 1; we_c = 0; wa_c = 0; wd_c = 0; rr_c = 0;
    test_reset();
    test_write();
    test_bypass();
    test_zero();
    test_reset_mid();
    test_random_ab();
    test_sweep_c();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
